// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one 1-cycle SRAM port, with per-requester lock
module sram_port_arbiter #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 13,
    parameter int DataWidth = 64,
    parameter int IdxWidth  = $clog2(NumReq)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq-1:0]               lock_i,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   be_i,
    output logic [NumReq-1:0]               gnt_o,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int BeWidth = DataWidth / 8;

    logic [IdxWidth-1:0] rr_ptr;
    logic [IdxWidth-1:0] lock_owner;
    logic                lock_owner_valid;
    logic                rsp_pending;
    logic [IdxWidth-1:0] rsp_idx;

    logic                gnt_valid;
    logic [IdxWidth-1:0] gnt_idx;
    logic [IdxWidth:0]   cand;

    // Lock owner wins while it keeps requesting; otherwise scan from rr_ptr with wrap.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (lock_owner_valid && req_i[lock_owner]) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_owner;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                cand = {1'b0, rr_ptr} + (IdxWidth+1)'(k);
                if (cand >= (IdxWidth+1)'(NumReq)) begin
                    cand = cand - (IdxWidth+1)'(NumReq);
                end
                if (!gnt_valid && req_i[cand[IdxWidth-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand[IdxWidth-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt_o       = '0;
        mem_req_o   = gnt_valid;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (gnt_valid) begin
            gnt_o[gnt_idx] = 1'b1;
            mem_we_o       = we_i[gnt_idx];
            mem_addr_o     = addr_i[int'(gnt_idx)*AddrWidth +: AddrWidth];
            mem_wdata_o    = wdata_i[int'(gnt_idx)*DataWidth +: DataWidth];
            mem_be_o       = be_i[int'(gnt_idx)*BeWidth +: BeWidth];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr           <= '0;
            lock_owner       <= '0;
            lock_owner_valid <= 1'b0;
            rsp_pending      <= 1'b0;
            rsp_idx          <= '0;
        end else begin
            rsp_pending <= gnt_valid;
            rsp_idx     <= gnt_idx;
            if (gnt_valid) begin
                rr_ptr           <= (gnt_idx == IdxWidth'(NumReq-1)) ? '0 : gnt_idx + 1'b1;
                lock_owner_valid <= lock_i[gnt_idx];
                if (lock_i[gnt_idx]) begin
                    lock_owner <= gnt_idx;
                end
            end else begin
                lock_owner_valid <= 1'b0;
            end
        end
    end

    // A response still in flight when reset arrives is dropped immediately.
    always_comb begin
        rvalid_o = '0;
        if (rsp_pending && !rst_i) begin
            rvalid_o[rsp_idx] = 1'b1;
        end
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [N-1:0]       req_i, we_i, lock_i;
    logic [N*AW-1:0]    addr_i;
    logic [N*DW-1:0]    wdata_i;
    logic [N*BW-1:0]    be_i;
    logic [N-1:0]       gnt_o, rvalid_o;
    logic [DW-1:0]      rdata_o;
    logic               mem_req_o, mem_we_o;
    logic [AW-1:0]      mem_addr_o;
    logic [DW-1:0]      mem_wdata_o;
    logic [BW-1:0]      mem_be_o;
    logic [DW-1:0]      mem_rdata_i;

    always #5 clk_i = ~clk_i;

    sram_port_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // SRAM environment: 1-cycle read latency, byte-masked writes, bench-side clear/preload.
    logic [DW-1:0] sram [0:8191];
    logic          clr, pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk_i) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) sram[i] <= '0;
        end else if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
            else          mem_rdata_i <= sram[mem_addr_o];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:63];
    int            m_rr, m_lock, exp_idx;
    bit            exp_pend, exp_rd;
    logic [DW-1:0] exp_data;
    int            n_tests, n_fail;

    logic [N-1:0]  og, orv;
    logic [DW-1:0] ord;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_lock >= 0 && req_i[m_lock]) return m_lock;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (req_i[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic r, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_i[i] = r; we_i[i] = w; lock_i[i] = l;
        addr_i[i*AW +: AW] = a; wdata_i[i*DW +: DW] = d; be_i[i*BW +: BW] = b;
    endtask

    task automatic clear_req();
        req_i = '0; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
    endtask

    // One clock cycle: sample at negedge, check against the model, advance the model, step past posedge.
    task automatic tick(output logic [N-1:0] o_gnt, output logic [N-1:0] o_rv, output logic [DW-1:0] o_rd);
        int            g, a;
        logic [N-1:0]  eg, erv;
        @(negedge clk_i);
        o_gnt = gnt_o; o_rv = rvalid_o; o_rd = rdata_o;
        g  = model_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", DW'(gnt_o), DW'(eg));
        chk("mem_req", DW'(mem_req_o), DW'(g >= 0));
        if (g >= 0) begin
            chk("mem_we", DW'(mem_we_o), DW'(we_i[g]));
            chk("mem_addr", DW'(mem_addr_o), DW'(addr_i[g*AW +: AW]));
            chk("mem_be", DW'(mem_be_o), DW'(be_i[g*BW +: BW]));
            chk("mem_wdata", mem_wdata_o, wdata_i[g*DW +: DW]);
        end else begin
            chk("mem_idle_ctl", DW'({mem_we_o, mem_addr_o, mem_be_o}), '0);
            chk("mem_idle_wdata", mem_wdata_o, '0);
        end
        erv = '0;
        if (exp_pend && !rst_i) erv[exp_idx] = 1'b1;
        chk("rvalid", DW'(rvalid_o), DW'(erv));
        if (exp_pend && !rst_i && exp_rd) chk("rdata", rdata_o, exp_data);
        if (rst_i) begin
            m_rr = 0; m_lock = -1; exp_pend = 1'b0;
        end else begin
            exp_pend = (g >= 0);
            if (g >= 0) begin
                a       = int'(addr_i[g*AW +: AW]);
                exp_idx = g;
                exp_rd  = !we_i[g];
                if (exp_rd) exp_data = ref_mem[a];
                else        ref_mem[a] = merge(ref_mem[a], wdata_i[g*DW +: DW], be_i[g*BW +: BW]);
                m_rr   = (g + 1) % N;
                m_lock = lock_i[g] ? g : -1;
            end else begin
                m_lock = -1;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_rr = 0; m_lock = -1; exp_pend = 1'b0; exp_rd = 1'b0; exp_idx = 0; exp_data = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        rst_i = 1'b1; clr = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        clear_req();

        // Reset: clear memory and preload while held
        clr = 1'b1;
        tick(og, orv, ord);
        clr = 1'b0;
        preload(13'h10, 64'hDEAD_BEEF_0123_4567);
        tick(og, orv, ord);
        preload(13'h20, 64'h1122_3344_5566_7788);
        tick(og, orv, ord);
        pl_en = 1'b0;
        chk("reset_rvalid", DW'(orv), '0);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(og, orv, ord);
            chk("idle_gnt", DW'(og), '0);
            chk("idle_rvalid", DW'(orv), '0);
        end

        // Single read
        set_req(0, 1'b1, 1'b0, 1'b0, 13'h10, '0, '0);
        tick(og, orv, ord);
        chk("single_gnt", DW'(og), 64'h1);
        clear_req();
        tick(og, orv, ord);
        chk("single_rvalid", DW'(orv), 64'h1);
        chk("single_rdata", ord, 64'hDEAD_BEEF_0123_4567);

        // Round-robin fairness from reset
        rst_i = 1'b1;
        tick(og, orv, ord);
        tick(og, orv, ord);
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 63)), '0, '0);
            set_req(1, 1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 63)), '0, '0);
            tick(og, orv, ord);
            chk("rr_gnt", DW'(og), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) chk("rr_rvalid", DW'(orv), (i % 2 == 0) ? 64'h2 : 64'h1);
        end
        clear_req();
        tick(og, orv, ord);
        chk("rr_rvalid_last", DW'(orv), 64'h2);

        // Locked read-modify-write against a continuously requesting req0
        set_req(0, 1'b1, 1'b0, 1'b0, 13'h01, '0, '0);
        tick(og, orv, ord);
        chk("pre_lock_gnt", DW'(og), 64'h1);
        set_req(1, 1'b1, 1'b0, 1'b1, 13'h20, '0, '0);
        tick(og, orv, ord);
        chk("lock_rd_gnt", DW'(og), 64'h2);
        set_req(1, 1'b1, 1'b1, 1'b1, 13'h20, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
        tick(og, orv, ord);
        chk("lock_wr_gnt", DW'(og), 64'h2);
        chk("lock_rd_rdata", ord, 64'h1122_3344_5566_7788);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick(og, orv, ord);
        chk("lock_after_gnt", DW'(og), 64'h1);
        clear_req();
        set_req(1, 1'b1, 1'b0, 1'b0, 13'h20, '0, '0);
        tick(og, orv, ord);
        chk("merge_rd_gnt", DW'(og), 64'h2);
        clear_req();
        tick(og, orv, ord);
        chk("merge_rvalid", DW'(orv), 64'h2);
        chk("merge_rdata", ord, 64'h1122_3344_BBBB_BBBB);

        // Lock released by a one-cycle gap
        set_req(1, 1'b1, 1'b0, 1'b1, 13'h05, '0, '0);
        tick(og, orv, ord);
        chk("gap_lock_gnt", DW'(og), 64'h2);
        clear_req();
        tick(og, orv, ord);
        set_req(0, 1'b1, 1'b0, 1'b0, 13'h06, '0, '0);
        set_req(1, 1'b1, 1'b0, 1'b1, 13'h07, '0, '0);
        tick(og, orv, ord);
        chk("gap_resume_gnt", DW'(og), 64'h1);

        // Reset in the cycle after a grant drops the response
        clear_req();
        set_req(0, 1'b1, 1'b0, 1'b0, 13'h10, '0, '0);
        tick(og, orv, ord);
        chk("midrst_gnt", DW'(og), 64'h1);
        clear_req();
        rst_i = 1'b1;
        tick(og, orv, ord);
        chk("midrst_rvalid0", DW'(orv), '0);
        tick(og, orv, ord);
        chk("midrst_rvalid1", DW'(orv), '0);
        rst_i = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 13'h11, '0, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 13'h12, '0, '0);
        tick(og, orv, ord);
        chk("midrst_after_gnt", DW'(og), 64'h1);
        chk("midrst_after_rvalid", DW'(orv), '0);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_i = 1'b1;
                clear_req();
            end else begin
                rst_i = 1'b0;
                for (int i = 0; i < N; i++) begin
                    set_req(i, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                            AW'($urandom_range(0, 63)), {$urandom, $urandom}, BW'($urandom));
                end
            end
            tick(og, orv, ord);
        end
        rst_i = 1'b0;
        clear_req();
        tick(og, orv, ord);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single-port, 1-cycle-latency on-chip SRAM (64-bit word, 8192 words) between NumReq memory-protocol requesters, for example several axi_to_mem front-ends or a DMA engine.
- Arbitrates requests round-robin, with an optional per-requester lock so read-modify-write sequences are atomic.
- Drives the SRAM port.
- Returns rvalid/rdata to the requester that was granted, exactly one cycle after the grant.

Parameters:
- NumReq, 2, number of requesters; allowed range 2..8.
- AddrWidth, 13, word address width.
- DataWidth, 64, data width in bits; must be a multiple of 8.
- IdxWidth, $clog2(NumReq), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumReq  per-requester request.
- we_i  in  NumReq  per-requester write enable.
- lock_i  in  NumReq  per-requester lock; keeps the grant while the requester's requests are back-to-back.
- addr_i  in  NumReq*AddrWidth  packed addresses; requester i occupies slice [i*AddrWidth +: AddrWidth].
- wdata_i  in  NumReq*DataWidth  packed write data.
- be_i  in  NumReq*DataWidth/8  packed byte enables.
- gnt_o  out  NumReq  grant, one-hot or zero, combinational.
- rvalid_o  out  NumReq  response valid, one cycle after grant.
- rdata_o  out  DataWidth  read data, broadcast to all requesters.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  AddrWidth  SRAM address.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_be_o  out  DataWidth/8  SRAM byte enables.
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after mem_req_o.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - rr_ptr=0, lock_owner_valid=0, rsp_pending=0, rsp_idx=0.
  - Hence rvalid_o=0 in the cycle after reset is asserted.
  - gnt_o and mem_* outputs are combinational from the inputs and state, so they follow the reset-state arbitration.
- A request pending when reset is asserted is dropped; no rvalid is returned for it.
- Arbitration (combinational, same cycle):
  - If lock_owner_valid and req_i[lock_owner]: grant lock_owner.
  - Otherwise grant the first i with req_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NumReq.
  - No request: gnt_o=0 and mem_req_o=0.
- Grant rules:
  - The SRAM always accepts, so at most one grant per cycle.
  - gnt_o[i]=1 means the request is consumed this cycle.
- Memory mux: mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are taken from the granted requester's slices. With no grant they are driven to 0.
- Pointer update on every grant to index g: rr_ptr <= (g==NumReq-1) ? 0 : g+1. With no grant, rr_ptr is unchanged.
- Lock register, on a grant to g:
  - lock_i[g]=1: lock_owner <= g, lock_owner_valid <= 1.
  - lock_i[g]=0: lock_owner_valid <= 0.
  - No grant in a cycle: lock_owner_valid <= 0, so the lock only holds across back-to-back requests.
- Lock interaction: the lock owner's grant overrides round-robin. rr_ptr still advances past the owner on each of its grants.
- Response pipeline:
  - rsp_pending <= mem_req_o, rsp_idx <= g.
  - rvalid_o = rsp_pending ? one-hot(rsp_idx) : 0.
- Reads and writes both produce exactly one rvalid pulse.
- rdata_o = mem_rdata_i, unregistered. It is only meaningful on a read response; on write responses its content is don't-care.
- Latency and throughput:
  - Grant to rvalid is exactly 1 cycle.
  - Full throughput: one access per cycle, with back-to-back grants to different requesters allowed.
- Simultaneous events: a new grant and the previous cycle's rvalid may target the same or different requesters in the same cycle. Both are legal.
- Requester protocol: req_i and the request fields may change freely while not granted. There is no hold requirement; the arbiter is stateless with respect to ungranted requests.

Test Plan:
- Reset and idle: rst_i=1 for 2 cycles, then all req_i=0 for 5 cycles -> gnt_o=0, mem_req_o=0 and rvalid_o=0 throughout.
- Single read:
  - Preload word 0x10 = 0xDEAD_BEEF_0123_4567.
  - req0 reads addr 0x10 -> gnt_o=01 in the same cycle, then rvalid_o=01 and rdata_o=0xDEAD_BEEF_0123_4567 the next cycle.
- Round-robin fairness:
  - req_i=11 held for 6 cycles from reset -> grants 01,10,01,10,01,10.
  - rvalid_o reproduces the same sequence delayed by 1 cycle.
- Lock for read-modify-write:
  - req1 with lock=1 reads 0x20, then writes 0x20 with be=0x0F in the next cycle, while req0 requests continuously.
  - Required: gnt_o=10 twice in a row, then 01.
  - A subsequent read of 0x20 returns merged bytes.
- Lock release by gap:
  - req1 lock=1 granted, req1 idle one cycle, then req_i=11 -> round-robin resumes.
  - Required: req0 granted, since rr_ptr=0 after req1's grant.
- Reset mid-operation:
  - Grant a read to req0, assert rst_i in the next cycle -> rvalid_o=0 in that cycle and afterwards.
  - After release, rr_ptr=0: the first grant with req_i=11 goes to req0.
